// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the 1024x18 RAT program memory
// Holds the CPU in reset while a frame of 3-byte instructions is written to sequential addresses.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              CPU_RST_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int N_W  = 11;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_FINISH
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      cnt_hi_q;
  logic [N_W-1:0]  n_q, idx_q, n_rx;
  logic [1:0]      b0_q;
  logic [7:0]      b1_q, xor_q;
  logic [TO_W-1:0] idle_q;
  logic            xfer, timer_active, timed_out, set_done, set_err;

  assign n_rx = {cnt_hi_q[2:0], RX_DATA};

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    set_done     = 1'b0;
    set_err      = 1'b0;
    RX_READY     = !RST && (state != S_WRITE) && (state != S_FINISH);
    xfer         = RX_VALID && RX_READY;
    timer_active = (state != S_IDLE) && (state != S_WRITE) && (state != S_FINISH);
    timed_out    = timer_active && !xfer && (idle_q == TO_W'(TIMEOUT - 1));
    WR_EN        = (state == S_WRITE);
    BUSY         = (state != S_IDLE) && (state != S_FINISH);
    case (state)
      S_IDLE:   if (xfer && RX_DATA == SYNC) state_nx = S_CNT_HI;
      S_CNT_HI: if (xfer) state_nx = S_CNT_LO;
      S_CNT_LO: if (xfer) begin
        if (cnt_hi_q[7:3] != 5'd0 || n_rx == '0 || n_rx > N_W'(1 << ADDR_W)) begin
          state_nx = S_FINISH;
          set_err  = 1'b1;
        end else begin
          state_nx = S_B0;
        end
      end
      S_B0: if (xfer) begin
        if (RX_DATA[7:2] != 6'd0) begin
          state_nx = S_FINISH;
          set_err  = 1'b1;
        end else begin
          state_nx = S_B1;
        end
      end
      S_B1:    if (xfer) state_nx = S_B2;
      S_B2:    if (xfer) state_nx = S_WRITE;
      S_WRITE: state_nx = (idx_q + N_W'(1) == n_q) ? S_CSUM : S_B0;
      S_CSUM: if (xfer) begin
        state_nx = S_FINISH;
        if (RX_DATA == xor_q) set_done = 1'b1;
        else                  set_err  = 1'b1;
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (timed_out) begin
      state_nx = S_FINISH;
      set_err  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_hi_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      xor_q        <= '0;
      idle_q       <= '0;
      WR_ADDR      <= '0;
      WR_DATA      <= '0;
      CPU_RST_HOLD <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      idle_q <= (!timer_active || xfer) ? '0 : idle_q + TO_W'(1);
      case (state)
        S_IDLE: if (xfer && RX_DATA == SYNC) begin
          CPU_RST_HOLD <= 1'b1;
          DONE         <= 1'b0;
          ERR          <= 1'b0;
          idx_q        <= '0;
          xor_q        <= '0;
        end
        S_CNT_HI: if (xfer) cnt_hi_q <= RX_DATA;
        S_CNT_LO: if (xfer) n_q <= n_rx;
        S_B0: if (xfer) begin
          b0_q  <= RX_DATA[1:0];
          xor_q <= xor_q ^ RX_DATA;
        end
        S_B1: if (xfer) begin
          b1_q  <= RX_DATA;
          xor_q <= xor_q ^ RX_DATA;
        end
        S_B2: if (xfer) begin
          xor_q   <= xor_q ^ RX_DATA;
          WR_ADDR <= idx_q[ADDR_W-1:0];
          WR_DATA <= {b0_q, b1_q, RX_DATA};
        end
        S_WRITE:  idx_q <= idx_q + N_W'(1);
        // A failed frame leaves memory partially written, so the CPU stays held.
        S_FINISH: if (DONE) CPU_RST_HOLD <= 1'b0;
        default: ;
      endcase
      if (set_done) DONE <= 1'b1;
      if (set_err)  ERR  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY, WR_EN, CPU_RST_HOLD, BUSY, DONE, ERR;
  logic [9:0]  WR_ADDR;
  logic [17:0] WR_DATA;

  prog_loader #(.ADDR_W(10), .DATA_W(18), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CPU_RST_HOLD(CPU_RST_HOLD),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  frame[$];
  logic [27:0] exp_wr[$];
  logic [27:0] obs_wr[$];
  int          obs_cyc[$];
  logic        exp_done, exp_err;
  logic        prev_wr = 1'b0;
  int          consec_wr = 0;
  int          wr_ready_viol = 0;
  logic        rl_en = 1'b0;
  int          rl_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (WR_EN) begin
        obs_wr.push_back({WR_ADDR, WR_DATA});
        obs_cyc.push_back(cyc);
        if (prev_wr) consec_wr++;
        if (RX_READY) wr_ready_viol++;
      end
      if (rl_en && !RX_READY) rl_cnt++;
    end
    prev_wr = WR_EN && !RST;
  end

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog");
  end

  // Spec-level reference: parse a frame and list the writes and final verdict it must produce.
  task automatic model_frame();
    logic [10:0] n;
    logic [7:0]  x, b0, b1, b2;
    int          p;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = {frame[1][2:0], frame[2]};
    if (frame[1][7:3] != 5'd0 || n == 11'd0 || n > 11'd1024) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    p = 3;
    for (int i = 0; i < int'(n); i++) begin
      if (p >= frame.size()) return;
      b0 = frame[p];
      if (b0[7:2] != 6'd0) begin
        exp_err = 1'b1;
        return;
      end
      if (p + 2 >= frame.size()) return;
      b1 = frame[p+1];
      b2 = frame[p+2];
      x = x ^ b0 ^ b1 ^ b2;
      exp_wr.push_back({10'(i), b0[1:0], b1, b2});
      p += 3;
    end
    if (p < frame.size()) begin
      if (frame[p] == x) exp_done = 1'b1;
      else               exp_err  = 1'b1;
    end
  endtask

  task automatic build_frame(input int nw, input bit corrupt);
    logic [10:0] nn;
    logic [7:0]  c, b;
    nn = 11'(nw);
    c  = 8'h00;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back({5'd0, nn[10:8]});
    frame.push_back(nn[7:0]);
    for (int i = 0; i < nw; i++) begin
      b = {6'd0, 2'($urandom)}; frame.push_back(b); c ^= b;
      b = 8'($urandom);         frame.push_back(b); c ^= b;
      b = 8'($urandom);         frame.push_back(b); c ^= b;
    end
    frame.push_back(corrupt ? (c ^ 8'h5A) : c);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    RX_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    #1;
    while (!RX_READY && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h ready=%b required=1", b, RX_READY);
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++) send_byte(frame[i], $urandom_range(0, maxgap));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (RX_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", RX_READY); end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({RX_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST_HOLD, BUSY, DONE, ERR} !== 34'h2_0000_0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {RX_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST_HOLD, BUSY, DONE, ERR}, 34'h2_0000_0000);
    end
  endtask

  task automatic test_single_word();
    frame = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h56, 8'h60};
    obs_wr.delete();
    send_byte(frame[0], 0);
    checks++;
    if ({CPU_RST_HOLD, BUSY} !== 2'b11) begin
      failures++; $display("FAIL single_hold_rise got=%b exp=11", {CPU_RST_HOLD, BUSY});
    end
    send_range(1, 6, 2);
    checks++;
    if ({BUSY, DONE, ERR, CPU_RST_HOLD} !== 4'b0101) begin
      failures++; $display("FAIL single_finish busy/done/err/hold got=%b exp=0101", {BUSY, DONE, ERR, CPU_RST_HOLD});
    end
    @(negedge CLK);
    checks++;
    if (obs_wr.size() != 1 || obs_wr[0] !== {10'd0, 18'h23456}) begin
      failures++; $display("FAIL single_write n=%0d got=%h exp=%h", obs_wr.size(), obs_wr[0], {10'd0, 18'h23456});
    end
    checks++;
    if ({DONE, ERR, CPU_RST_HOLD} !== 3'b100) begin
      failures++; $display("FAIL single_idle done/err/hold got=%b exp=100", {DONE, ERR, CPU_RST_HOLD});
    end
  endtask

  task automatic test_bad_checksum();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    obs_wr.delete();
    send_range(0, 9, 1);
    repeat (2) @(negedge CLK);
    checks++;
    if (obs_wr.size() != 2 || obs_wr[0] !== {10'd0, 18'h10000} || obs_wr[1] !== {10'd1, 18'h000FF}) begin
      failures++; $display("FAIL csum_writes n=%0d got0=%h got1=%h exp=%h,%h", obs_wr.size(), obs_wr[0], obs_wr[1],
                           {10'd0, 18'h10000}, {10'd1, 18'h000FF});
    end
    checks++;
    if ({DONE, ERR, CPU_RST_HOLD, BUSY} !== 4'b0110) begin
      failures++; $display("FAIL csum_status done/err/hold/busy got=%b exp=0110", {DONE, ERR, CPU_RST_HOLD, BUSY});
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] hdr[4][$];
    hdr[0] = '{8'hA5, 8'h04, 8'h01};
    hdr[1] = '{8'hA5, 8'h00, 8'h00};
    hdr[2] = '{8'hA5, 8'h08, 8'h01};
    hdr[3] = '{8'hA5, 8'h00, 8'h01, 8'h04};
    for (int t = 0; t < 4; t++) begin
      frame = hdr[t];
      model_frame();
      obs_wr.delete();
      send_range(0, frame.size() - 1, 1);
      checks++;
      if ({BUSY, ERR} !== 2'b01) begin
        failures++; $display("FAIL hdr%0d_finish busy/err got=%b exp=01", t, {BUSY, ERR});
      end
      repeat (2) @(negedge CLK);
      checks++;
      if (obs_wr.size() != exp_wr.size() || {DONE, ERR, CPU_RST_HOLD} !== {exp_done, exp_err, 1'b1}) begin
        failures++; $display("FAIL hdr%0d nwr=%0d done/err/hold=%b exp nwr=%0d %b", t, obs_wr.size(),
                             {DONE, ERR, CPU_RST_HOLD}, exp_wr.size(), {exp_done, exp_err, 1'b1});
      end
    end
  endtask

  task automatic test_full_load();
    logic [7:0] old;
    build_frame(1024, 1'b0);
    old = frame[19];
    frame[19] = 8'hA5;
    frame[frame.size()-1] ^= old ^ 8'hA5;
    model_frame();
    obs_wr.delete();
    rl_cnt = 0;
    consec_wr = 0;
    wr_ready_viol = 0;
    rl_en = 1'b1;
    send_range(0, frame.size() - 1, 7);
    @(negedge CLK);
    rl_en = 1'b0;
    checks++;
    if (obs_wr.size() != 1024) begin
      failures++; $display("FAIL full_count got=%0d exp=1024", obs_wr.size());
    end
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++;
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) begin
        failures++; $display("FAIL full_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if ({DONE, ERR, CPU_RST_HOLD} !== {exp_done, exp_err, 1'b0} || exp_done !== 1'b1) begin
      failures++; $display("FAIL full_status done/err/hold got=%b exp=100", {DONE, ERR, CPU_RST_HOLD});
    end
    checks++;
    if (rl_cnt != 1025 || consec_wr != 0 || wr_ready_viol != 0) begin
      failures++; $display("FAIL full_ready lowcycles=%0d consec=%0d wr_ready=%0d exp 1025/0/0",
                           rl_cnt, consec_wr, wr_ready_viol);
    end
  endtask

  task automatic test_back_to_back();
    build_frame(6, 1'b0);
    model_frame();
    obs_wr.delete();
    obs_cyc.delete();
    send_range(0, frame.size() - 1, 0);
    @(negedge CLK);
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++;
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) begin
        failures++; $display("FAIL b2b_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
        failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, obs_cyc[i] - obs_cyc[i-1]);
      end
    end
    checks++;
    if ({DONE, ERR} !== {exp_done, exp_err}) begin
      failures++; $display("FAIL b2b_status got=%b exp=%b", {DONE, ERR}, {exp_done, exp_err});
    end
  endtask

  task automatic test_timeout();
    int early;
    build_frame(2, 1'b0);
    obs_wr.delete();
    send_range(0, 4, 1);
    early = 0;
    repeat (15) begin
      if (ERR !== 1'b0 || BUSY !== 1'b1) early++;
      @(negedge CLK);
    end
    checks++;
    if (early != 0 || ERR !== 1'b0) begin
      failures++; $display("FAIL timeout_early bad_cycles=%0d err=%b exp 0/0", early, ERR);
    end
    @(negedge CLK);
    checks++;
    if ({ERR, BUSY, DONE} !== 3'b100 || obs_wr.size() != 0) begin
      failures++; $display("FAIL timeout_fire err/busy/done=%b nwr=%0d exp 100/0", {ERR, BUSY, DONE}, obs_wr.size());
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_midframe();
    build_frame(10, 1'b0);
    obs_wr.delete();
    send_range(0, 16, 2);
    RST = 1'b1;
    #1;
    checks++;
    if (RX_READY !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", RX_READY); end
    @(negedge CLK);
    checks++;
    if ({RX_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST_HOLD, BUSY, DONE, ERR} !== 34'h0 || obs_wr.size() != 4) begin
      failures++;
      $display("FAIL mid_rst_outputs got=%h exp=0 nwr=%0d exp=4",
               {RX_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST_HOLD, BUSY, DONE, ERR}, obs_wr.size());
    end
    RST = 1'b0;
    @(negedge CLK);
    build_frame(3, 1'b0);
    model_frame();
    obs_wr.delete();
    send_range(0, frame.size() - 1, 3);
    @(negedge CLK);
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++;
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) begin
        failures++; $display("FAIL mid_reload_wr[%0d] got=%h exp=%h", i, obs_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if ({DONE, ERR, CPU_RST_HOLD} !== 3'b100 || exp_done !== 1'b1) begin
      failures++; $display("FAIL mid_reload_status done/err/hold got=%b exp=100", {DONE, ERR, CPU_RST_HOLD});
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_bad_header();
    test_full_load();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
